button_conditioner: RTL and testbench



---
 rtl/watch_pkg.sv | 17 +
 rtl/button_channel.sv | 141 ++++++++++++++
 rtl/button_conditioner.sv | 61 ++++++
 tb/tb_button_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants and types for the watch front-end.
package watch_pkg;

  // Default timing at the 10 kHz watch clock
  localparam int unsigned CNT_W_DEF          = 16;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 200;   // 20 ms
  localparam int unsigned HOLD_TICKS_DEF     = 5000;  // 500 ms
  localparam int unsigned REPEAT_TICKS_DEF   = 1000;  // 100 ms

  // Auto-repeat state of a button channel
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

endpackage

// File: rtl/button_channel.sv
// One push-button conditioning channel: 2-flop synchroniser, debounce
// filter, press-edge pulse and an optional hold/auto-repeat FSM.
//
// Ports:
//   clk      in   watch system clock
//   reset    in   synchronous, active-high reset
//   i_btn    in   raw asynchronous button (1 = pressed)
//   o_pulse  out  one-cycle pulse per debounced press and per auto-repeat
//   o_level  out  debounced button level
module button_channel
  import watch_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned HOLD_TICKS     = HOLD_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS   = REPEAT_TICKS_DEF,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level
);

  // Terminal counts; each counter reloads at its terminal value, so none wrap
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] w_deb_cnt_nxt;

  rep_state_e       r_state;
  rep_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_rep_pulse;

  logic             w_mismatch;
  logic             w_deb_done;
  logic             w_rise;
  logic             w_fall;

  // Debounced level flips once the synchronised input has disagreed with it
  // for DEBOUNCE_TICKS consecutive cycles
  assign w_mismatch = (r_s2 != r_level);
  assign w_deb_done = w_mismatch && (r_deb_cnt == DEB_LAST);
  assign w_rise     = w_deb_done && r_s2;
  assign w_fall     = w_deb_done && !r_s2;

  // Mismatch run-length counter: clears on agreement and on the flip itself
  always_comb begin
    w_deb_cnt_nxt = '0;
    if (w_mismatch && !w_deb_done) begin
      w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
    end
  end

  // Synchroniser, debounce state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_deb_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_s1      <= i_btn;
      r_s2      <= r_s1;
      r_deb_cnt <= w_deb_cnt_nxt;
      if (w_deb_done) begin
        r_level <= r_s2;
      end
      r_pulse   <= w_rise || w_rep_pulse;
    end
  end

  // Repeat FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Repeat FSM next state; a debounced fall wins over a due repeat pulse
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_rep_pulse    = 1'b0;
    if (REPEAT_EN) begin
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = '0;
          end
        end
        HOLD: begin
          if (w_fall) begin
            w_state_nxt    = IDLE;
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            w_rep_pulse    = 1'b1;
            w_state_nxt    = REPEAT;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (w_fall) begin
            w_state_nxt    = IDLE;
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt == REP_LAST) begin
            w_rep_pulse    = 1'b1;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw mode and increment push-buttons for the watch.
// The increment channel auto-repeats while held; the mode channel does not.
//
// Ports:
//   clk         in   watch system clock
//   reset       in   synchronous, active-high reset
//   mode_btn    in   raw mode button (1 = pressed)
//   inc_btn     in   raw increment button (1 = pressed)
//   mode_pulse  out  one-cycle pulse per debounced mode press
//   inc_pulse   out  one-cycle pulse per debounced increment press / repeat
//   mode_level  out  debounced mode level
//   inc_level   out  debounced increment level
module button_conditioner
  import watch_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned HOLD_TICKS     = HOLD_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic mode_btn,
  input  logic inc_btn,
  output logic mode_pulse,
  output logic inc_pulse,
  output logic mode_level,
  output logic inc_level
);

  // Mode button: press pulse only
  button_channel #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .HOLD_TICKS     (HOLD_TICKS),
    .REPEAT_TICKS   (REPEAT_TICKS),
    .REPEAT_EN      (1'b0)
  ) u_mode (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (mode_btn),
    .o_pulse (mode_pulse),
    .o_level (mode_level)
  );

  // Increment button: press pulse plus auto-repeat
  button_channel #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .HOLD_TICKS     (HOLD_TICKS),
    .REPEAT_TICKS   (REPEAT_TICKS),
    .REPEAT_EN      (1'b1)
  ) u_inc (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (inc_btn),
    .o_pulse (inc_pulse),
    .o_level (inc_level)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short tick parameters.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned H = 10;
  localparam int unsigned R = 3;

  typedef struct packed {
    logic ml;
    logic mp;
    logic il;
    logic ip;
  } exp_t;

  logic clk;
  logic reset;
  logic mode_btn;
  logic inc_btn;
  logic mode_pulse;
  logic inc_pulse;
  logic mode_level;
  logic inc_level;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .CNT_W          (16),
    .DEBOUNCE_TICKS (D),
    .HOLD_TICKS     (H),
    .REPEAT_TICKS   (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .mode_level (mode_level),
    .inc_level  (inc_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips when the last D synchronised samples all
  // disagree with it; repeats fall at H, H+R, H+2R ... edges after the press.
  logic         m_s1   [2];
  logic         m_s2   [2];
  logic         m_lvl  [2];
  logic [D-1:0] m_hist [2];
  int           m_press[2];
  int           cyc = 0;
  exp_t         sb[$];

  always @(posedge clk) begin : model
    exp_t e;
    logic raw [2];
    logic rise;
    logic rep;
    int   el;
    raw[0] = mode_btn;
    raw[1] = inc_btn;
    cyc++;
    e = '0;
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch]    = 1'b0;
        m_s2[ch]    = 1'b0;
        m_lvl[ch]   = 1'b0;
        m_hist[ch]  = '0;
        m_press[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_hist[ch] = {m_hist[ch][D-2:0], m_s2[ch]};
        rise = 1'b0;
        rep  = 1'b0;
        if (m_hist[ch] == {D{!m_lvl[ch]}}) begin
          m_lvl[ch] = !m_lvl[ch];
          rise      = m_lvl[ch];
          if (rise) m_press[ch] = cyc;
        end else if (ch == 1 && m_lvl[ch]) begin
          el  = cyc - m_press[ch];
          rep = (el >= int'(H)) && (((el - int'(H)) % int'(R)) == 0);
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw[ch];
        if (ch == 0) begin
          e.ml = m_lvl[0];
          e.mp = rise;
        end else begin
          e.il = m_lvl[1];
          e.ip = rise | rep;
        end
      end
    end
    sb.push_back(e);
  end

  // Per-cycle scoreboard compare, away from the active edge
  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle_outs", 32'({mode_level, mode_pulse, inc_level, inc_pulse}), 32'(e));
    end
  end

  // Advance n cycles, counting DUT pulses and noting the first pulse edge
  task automatic run(input int n, output int n_m, output int n_i,
                     output int f_m, output int f_i);
    n_m = 0; n_i = 0; f_m = 0; f_i = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (mode_pulse === 1'b1) begin
        n_m++;
        if (f_m == 0) f_m = i;
      end
      if (inc_pulse === 1'b1) begin
        n_i++;
        if (f_i == 0) f_i = i;
      end
    end
  endtask

  initial begin : stim
    int nm, ni, fm, fi, acc_m, acc_i;
    reset = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({mode_level, mode_pulse, inc_level, inc_pulse}), 32'd0);

    // Buttons already held when reset releases
    reset = 1'b0;
    run(8, nm, ni, fm, fi);
    check("rst_rel_mode_first", 32'(fm), 32'd6);
    check("rst_rel_inc_first", 32'(fi), 32'd6);
    mode_btn = 1'b0; inc_btn = 1'b0;
    run(12, nm, ni, fm, fi);
    check("rst_rel_release_nopulse", 32'(nm + ni), 32'd0);

    // Clean press and release
    inc_btn = 1'b1;
    run(8, nm, ni, fm, fi);
    check("clean_first", 32'(fi), 32'd6);
    check("clean_count", 32'(ni), 32'd1);
    inc_btn = 1'b0;
    run(8, nm, ni, fm, fi);
    check("clean_release_nopulse", 32'(ni), 32'd0);
    check("clean_release_level", 32'(inc_level), 32'd0);

    // Bounce shorter than the debounce window
    acc_m = 0;
    for (int i = 0; i < 10; i++) begin
      mode_btn = ~mode_btn;
      run(1, nm, ni, fm, fi);
      acc_m += nm;
    end
    mode_btn = 1'b0;
    run(8, nm, ni, fm, fi);
    acc_m += nm;
    check("bounce_nopulse", 32'(acc_m), 32'd0);
    check("bounce_level", 32'(mode_level), 32'd0);

    // Long hold: press at 6 then repeats at 16,19,...,34; fall at 36
    inc_btn = 1'b1;
    run(30, nm, ni, fm, fi);
    acc_i = ni;
    check("hold_first", 32'(fi), 32'd6);
    inc_btn = 1'b0;
    run(10, nm, ni, fm, fi);
    acc_i += ni;
    check("hold_pulse_count", 32'(acc_i), 32'd8);

    mode_btn = 1'b1;
    run(30, nm, ni, fm, fi);
    acc_m = nm;
    mode_btn = 1'b0;
    run(10, nm, ni, fm, fi);
    acc_m += nm;
    check("mode_hold_single", 32'(acc_m), 32'd1);

    // Short low glitch during HOLD leaves the first repeat at P+10
    inc_btn = 1'b1;
    run(6, nm, ni, fm, fi);
    check("glitch_press", 32'(fi), 32'd6);
    run(5, nm, ni, fm, fi);
    check("glitch_quiet", 32'(ni), 32'd0);
    inc_btn = 1'b0;
    run(2, nm, ni, fm, fi);
    inc_btn = 1'b1;
    run(3, nm, ni, fm, fi);
    check("glitch_repeat_at_p10", 32'(fi), 32'd3);
    check("glitch_level_held", 32'(inc_level), 32'd1);
    inc_btn = 1'b0;
    run(12, nm, ni, fm, fi);

    // Reset in the middle of HOLD, button still held
    inc_btn = 1'b1;
    run(6, nm, ni, fm, fi);
    run(5, nm, ni, fm, fi);
    reset = 1'b1;
    run(1, nm, ni, fm, fi);
    check("midhold_reset_outs", 32'({mode_level, mode_pulse, inc_level, inc_pulse}), 32'd0);
    reset = 1'b0;
    run(8, nm, ni, fm, fi);
    check("midhold_repress", 32'(fi), 32'd6);
    inc_btn = 1'b0;
    run(12, nm, ni, fm, fi);

    // Simultaneous presses
    mode_btn = 1'b1; inc_btn = 1'b1;
    run(8, nm, ni, fm, fi);
    check("simul_mode_first", 32'(fm), 32'd6);
    check("simul_inc_first", 32'(fi), 32'd6);
    check("simul_mode_count", 32'(nm), 32'd1);
    check("simul_inc_count", 32'(ni), 32'd1);
    mode_btn = 1'b0; inc_btn = 1'b0;
    run(12, nm, ni, fm, fi);
    check("final_levels", 32'({mode_level, inc_level}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
